bdu_scheduler: RTL and testbench
================================

Name: bdu_scheduler

Overview:
Sequencing controller for one bit-serial distance unit (BDU) in the KNN accelerator. Latches a query point and accepts candidate reference points over a valid/ready stream. Serializes each query/candidate pair MSB-first, interleaved x,y,z, into the BDU, and drives its dimension code, bit position and threshold. Aborts a candidate on early termination and forwards survivors (distance below the current kth-best threshold) to the KNN insertion stage.

Parameters:
B, 32, bit width per dimension (BDU datapath width)
IDW, 16, candidate identifier width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
q_valid  in  1  query point offered
q_ready  out  1  query accepted (high only in IDLE)
q_point  in  3*B  query {z,y,x}, x in low B bits
r_valid  in  1  candidate offered
r_ready  out  1  candidate accepted (high only in WAIT_R)
r_point  in  3*B  candidate {z,y,x}
r_id  in  IDW  candidate identifier
r_last  in  1  final candidate for current query
threshold  in  2*B  current kth-best squared distance from KNN list
bdu_rst  out  1  BDU accumulator clear
bdu_q_bit  out  1  query bit this cycle
bdu_r_bit  out  1  candidate bit this cycle
bdu_code  out  2  dimension select: 01=x, 10=y, 11=z, 00=idle
bdu_which_bit  out  7  2*p, p = current bit position
bdu_threshold  out  2*B  threshold frozen for current candidate
bdu_terminate  in  1  BDU early-abort (partial exceeds threshold)
bdu_done  in  1  final distance below threshold
bdu_partial_distance  in  B  BDU distance result
res_valid  out  1  surviving candidate presented
res_ready  in  1  KNN insertion accepts result
res_id  out  IDW  surviving candidate id
res_dist  out  2*B  zero-extended bdu_partial_distance
query_done  out  1  one-cycle pulse after r_last candidate resolved
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0 except bdu_rst=1 and q_ready=1. Query, candidate and threshold registers cleared.
- bdu_rst = rst OR (state==CLEAR).
- IDLE: q_ready=1. On q_valid, latch q_point -> WAIT_R.
- WAIT_R: r_ready=1. On r_valid, latch r_point, r_id, r_last, and threshold into bdu_threshold -> CLEAR. bdu_threshold stays stable until the next acceptance.
- CLEAR: one cycle, bdu_code=00 -> STREAM with p=B-1, dim=x.
- STREAM: 3*B cycles. Each cycle drives q/r bit p of current dim, bdu_code per dim, bdu_which_bit=2*p. Dim cycles x->y->z; after z, p decrements. Leaves after cycle (p=0, dim=z) -> DRAIN.
- Early abort: bdu_terminate sampled 1 in STREAM -> candidate discarded, bdu_code=00 next cycle, -> RESOLVE. Takes priority even on the final STREAM cycle.
- DRAIN: one cycle, code 00. Sample bdu_done: 1 -> EMIT (res_id, res_dist registered). 0 -> RESOLVE (discard).
- EMIT: res_valid held with stable data until res_ready -> RESOLVE. No new candidate is accepted while in EMIT.
- RESOLVE: one cycle. If latched r_last: pulse query_done -> IDLE. Else -> WAIT_R.
- Latency, acceptance to res_valid, no abort: 1 + 3*B + 1 + 1 cycles (99 at B=32).
- Threshold changes during a candidate are ignored until the next acceptance.
- rst mid-operation: state and outputs return to reset values in the next cycle. Any pending result is dropped; no query_done pulse.
- bdu_which_bit width 7 is fixed; B must be <= 64 (elaboration assertion).

Optional Feature:
BDU_SCHED_STATS_EN: when defined, adds outputs stat_pruned[31:0] (early aborts plus DRAIN discards) and stat_emitted[31:0] (EMIT handshakes completed). Both are saturating, cleared on rst and on query acceptance. When undefined, the ports are absent and no counters are built.

Decomposition:
- Shared package knn_pkg:
  - dim_code_e enum (IDLE=00, X=01, Y=10, Z=11)
  - sched_state_e enum (IDLE, WAIT_R, CLEAR, STREAM, DRAIN, EMIT, RESOLVE)
  - localparam B default
- One sub-module, bdu_bit_serializer: holds the p/dim counters and bit muxing, exposes stream_last.
- FSM and handshakes stay in bdu_scheduler.

Test Plan:
- B=8, q=(3,4,0), r=(0,0,0), threshold=100, behavioural BDU model -> 24 STREAM cycles, code sequence 01,10,11 repeating, which_bit 14..0; res_valid with res_dist=25 at cycle 27 after acceptance.
- Same point, threshold=10, model asserts terminate at STREAM cycle 20 -> no res_valid, r_ready high 2 cycles later; stats pruned=1.
- Two candidates, second with r_last=1, both survive, res_ready held low 5 cycles on the first -> res_valid held stable; second not accepted before handshake; query_done pulses once after the second.
- threshold changes from 100 to 5 mid-STREAM -> bdu_threshold stays 100; candidate emitted.
- rst asserted in STREAM cycle 10 -> next cycle IDLE, bdu_rst=1, q_ready=1, res_valid=0, no query_done.
- terminate and final STREAM cycle coincide -> discard, no EMIT.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared types for the KNN accelerator BDU scheduling path.
package knn_pkg;

  localparam int KNN_B = 32;

  typedef enum logic [1:0] {
    DIM_IDLE = 2'b00,
    DIM_X    = 2'b01,
    DIM_Y    = 2'b10,
    DIM_Z    = 2'b11
  } dim_code_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_R  = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_EMIT    = 3'd5,
    ST_RESOLVE = 3'd6
  } sched_state_e;

  // Interleave order x -> y -> z -> x.
  function automatic dim_code_e next_dim(input dim_code_e d);
    dim_code_e n;
    case (d)
      DIM_X:   n = DIM_Y;
      DIM_Y:   n = DIM_Z;
      default: n = DIM_X;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bdu_bit_serializer.sv
// Bit-position / dimension counters and MSB-first bit muxing for one BDU.
module bdu_bit_serializer
  import knn_pkg::*;
#(
  parameter int B = KNN_B
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_advance,
  input  logic           i_active,
  input  logic [3*B-1:0] i_q_point,
  input  logic [3*B-1:0] i_r_point,
  output logic           o_q_bit,
  output logic           o_r_bit,
  output logic [1:0]     o_code,
  output logic [6:0]     o_which_bit,
  output logic           o_stream_last
);

  localparam int PW = (B > 1) ? $clog2(B) : 1;

  logic [PW-1:0] r_p;
  dim_code_e     r_dim;
  logic [B-1:0]  w_q_dim;
  logic [B-1:0]  w_r_dim;

  // Counter update: load MSB/x, then step dimension, decrementing p after z.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p   <= '0;
      r_dim <= DIM_IDLE;
    end else if (i_load) begin
      r_p   <= PW'(B - 1);
      r_dim <= DIM_X;
    end else if (i_advance) begin
      r_dim <= next_dim(r_dim);
      if (r_dim == DIM_Z) begin
        r_p <= r_p - PW'(1);
      end
    end
  end

  // Select the current dimension slice from both points.
  always_comb begin
    w_q_dim = i_q_point[B-1:0];
    w_r_dim = i_r_point[B-1:0];
    case (r_dim)
      DIM_Y: begin
        w_q_dim = i_q_point[2*B-1:B];
        w_r_dim = i_r_point[2*B-1:B];
      end
      DIM_Z: begin
        w_q_dim = i_q_point[3*B-1:2*B];
        w_r_dim = i_r_point[3*B-1:2*B];
      end
      default: begin
        w_q_dim = i_q_point[B-1:0];
        w_r_dim = i_r_point[B-1:0];
      end
    endcase
  end

  assign o_q_bit       = i_active ? w_q_dim[r_p] : 1'b0;
  assign o_r_bit       = i_active ? w_r_dim[r_p] : 1'b0;
  assign o_code        = i_active ? r_dim : DIM_IDLE;
  assign o_which_bit   = i_active ? 7'({r_p, 1'b0}) : 7'd0;
  assign o_stream_last = i_active && (r_p == '0) && (r_dim == DIM_Z);

endmodule

// File: rtl/bdu_scheduler.sv
// Sequencing controller for one bit-serial distance unit.
// Optional counters stat_pruned/stat_emitted built when BDU_SCHED_STATS_EN is defined.
module bdu_scheduler
  import knn_pkg::*;
#(
  parameter int B   = KNN_B,
  parameter int IDW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           q_valid,
  output logic           q_ready,
  input  logic [3*B-1:0] q_point,
  input  logic           r_valid,
  output logic           r_ready,
  input  logic [3*B-1:0] r_point,
  input  logic [IDW-1:0] r_id,
  input  logic           r_last,
  input  logic [2*B-1:0] threshold,
  output logic           bdu_rst,
  output logic           bdu_q_bit,
  output logic           bdu_r_bit,
  output logic [1:0]     bdu_code,
  output logic [6:0]     bdu_which_bit,
  output logic [2*B-1:0] bdu_threshold,
  input  logic           bdu_terminate,
  input  logic           bdu_done,
  input  logic [B-1:0]   bdu_partial_distance,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [IDW-1:0] res_id,
  output logic [2*B-1:0] res_dist,
  output logic           query_done,
  output logic           busy
`ifdef BDU_SCHED_STATS_EN
  ,
  output logic [31:0]    stat_pruned,
  output logic [31:0]    stat_emitted
`endif
);

  if (B < 1 || B > 64) begin : g_b_range
    $error("bdu_scheduler: B must be in 1..64 (bdu_which_bit is 7 bits)");
  end

  sched_state_e   r_state;
  sched_state_e   w_next_state;
  logic [3*B-1:0] r_q_point;
  logic [3*B-1:0] r_r_point;
  logic [IDW-1:0] r_r_id;
  logic           r_r_last;
  logic [2*B-1:0] r_threshold;
  logic [IDW-1:0] r_res_id;
  logic [2*B-1:0] r_res_dist;
  logic           w_q_acc;
  logic           w_r_acc;
  logic           w_stream_last;

  assign w_q_acc = (r_state == ST_IDLE) && q_valid;
  assign w_r_acc = (r_state == ST_WAIT_R) && r_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; terminate wins over the final stream cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    w_next_state = q_valid ? ST_WAIT_R : ST_IDLE;
      ST_WAIT_R:  w_next_state = r_valid ? ST_CLEAR : ST_WAIT_R;
      ST_CLEAR:   w_next_state = ST_STREAM;
      ST_STREAM: begin
        if (bdu_terminate) begin
          w_next_state = ST_RESOLVE;
        end else if (w_stream_last) begin
          w_next_state = ST_DRAIN;
        end else begin
          w_next_state = ST_STREAM;
        end
      end
      ST_DRAIN:   w_next_state = bdu_done ? ST_EMIT : ST_RESOLVE;
      ST_EMIT:    w_next_state = res_ready ? ST_RESOLVE : ST_EMIT;
      ST_RESOLVE: w_next_state = r_r_last ? ST_IDLE : ST_WAIT_R;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Query/candidate/threshold latches and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_point   <= '0;
      r_r_point   <= '0;
      r_r_id      <= '0;
      r_r_last    <= 1'b0;
      r_threshold <= '0;
      r_res_id    <= '0;
      r_res_dist  <= '0;
    end else begin
      if (w_q_acc) begin
        r_q_point <= q_point;
      end
      if (w_r_acc) begin
        r_r_point   <= r_point;
        r_r_id      <= r_id;
        r_r_last    <= r_last;
        r_threshold <= threshold;
      end
      if ((r_state == ST_DRAIN) && bdu_done) begin
        r_res_id   <= r_r_id;
        r_res_dist <= {{B{1'b0}}, bdu_partial_distance};
      end
    end
  end

  bdu_bit_serializer #(.B(B)) u_ser (
    .clk          (clk),
    .rst          (rst),
    .i_load       (r_state == ST_CLEAR),
    .i_advance    (r_state == ST_STREAM),
    .i_active     (r_state == ST_STREAM),
    .i_q_point    (r_q_point),
    .i_r_point    (r_r_point),
    .o_q_bit      (bdu_q_bit),
    .o_r_bit      (bdu_r_bit),
    .o_code       (bdu_code),
    .o_which_bit  (bdu_which_bit),
    .o_stream_last(w_stream_last)
  );

  assign q_ready       = (r_state == ST_IDLE);
  assign r_ready       = (r_state == ST_WAIT_R);
  assign bdu_rst       = rst || (r_state == ST_CLEAR);
  assign bdu_threshold = r_threshold;
  assign res_valid     = (r_state == ST_EMIT);
  assign res_id        = r_res_id;
  assign res_dist      = r_res_dist;
  assign query_done    = (r_state == ST_RESOLVE) && r_r_last;
  assign busy          = (r_state != ST_IDLE);

`ifdef BDU_SCHED_STATS_EN
  logic [31:0] r_stat_pruned;
  logic [31:0] r_stat_emitted;
  logic        w_prune;
  logic        w_emit;

  assign w_prune = ((r_state == ST_STREAM) && bdu_terminate) ||
                   ((r_state == ST_DRAIN) && !bdu_done);
  assign w_emit  = (r_state == ST_EMIT) && res_ready;

  // Saturating per-query counters, restarted on each query acceptance.
  always_ff @(posedge clk) begin
    if (rst || w_q_acc) begin
      r_stat_pruned  <= 32'd0;
      r_stat_emitted <= 32'd0;
    end else begin
      if (w_prune && (r_stat_pruned != 32'hFFFF_FFFF)) begin
        r_stat_pruned <= r_stat_pruned + 32'd1;
      end
      if (w_emit && (r_stat_emitted != 32'hFFFF_FFFF)) begin
        r_stat_emitted <= r_stat_emitted + 32'd1;
      end
    end
  end

  assign stat_pruned  = r_stat_pruned;
  assign stat_emitted = r_stat_emitted;
`endif

endmodule

// File: tb/tb_bdu_scheduler.sv
// Self-checking bench for bdu_scheduler at B=8 with a behavioural BDU model.
module tb_bdu_scheduler;

  localparam int BB  = 8;
  localparam int IDW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            q_valid;
  logic            q_ready;
  logic [3*BB-1:0] q_point;
  logic            r_valid;
  logic            r_ready;
  logic [3*BB-1:0] r_point;
  logic [IDW-1:0]  r_id;
  logic            r_last;
  logic [2*BB-1:0] threshold;
  logic            bdu_rst;
  logic            bdu_q_bit;
  logic            bdu_r_bit;
  logic [1:0]      bdu_code;
  logic [6:0]      bdu_which_bit;
  logic [2*BB-1:0] bdu_threshold;
  logic            bdu_terminate;
  logic            bdu_done;
  logic [BB-1:0]   bdu_partial_distance;
  logic            res_valid;
  logic            res_ready;
  logic [IDW-1:0]  res_id;
  logic [2*BB-1:0] res_dist;
  logic            query_done;
  logic            busy;
`ifdef BDU_SCHED_STATS_EN
  logic [31:0]     stat_pruned;
  logic [31:0]     stat_emitted;
`endif

  bdu_scheduler #(.B(BB), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .q_valid(q_valid), .q_ready(q_ready), .q_point(q_point),
    .r_valid(r_valid), .r_ready(r_ready), .r_point(r_point),
    .r_id(r_id), .r_last(r_last), .threshold(threshold),
    .bdu_rst(bdu_rst), .bdu_q_bit(bdu_q_bit), .bdu_r_bit(bdu_r_bit),
    .bdu_code(bdu_code), .bdu_which_bit(bdu_which_bit),
    .bdu_threshold(bdu_threshold), .bdu_terminate(bdu_terminate),
    .bdu_done(bdu_done), .bdu_partial_distance(bdu_partial_distance),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_dist(res_dist), .query_done(query_done), .busy(busy)
`ifdef BDU_SCHED_STATS_EN
    , .stat_pruned(stat_pruned), .stat_emitted(stat_emitted)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int qv[3];
  int exp_pruned  = 0;
  int exp_emitted = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3*BB-1:0] pack(input int x, input int y, input int z);
    return {BB'(z), BB'(y), BB'(x)};
  endfunction

  task automatic check_stats();
`ifdef BDU_SCHED_STATS_EN
    check("stat_pruned", stat_pruned, exp_pruned);
    check("stat_emitted", stat_emitted, exp_emitted);
`endif
  endtask

  // Entered at the negedge of an IDLE cycle; leaves at the negedge of the WAIT_R cycle.
  task automatic start_query(input int x, input int y, input int z);
    check("idle_q_ready", q_ready, 1);
    check("idle_busy", busy, 0);
    qv[0] = x; qv[1] = y; qv[2] = z;
    q_point = pack(x, y, z);
    q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    q_point = 24'($urandom);
    exp_pruned  = 0;
    exp_emitted = 0;
  endtask

  // Entered at the negedge of a WAIT_R cycle; leaves at the negedge after RESOLVE.
  task automatic run_cand(input int rx, input int ry, input int rz, input logic [IDW-1:0] id,
                          input logic last, input int thr, input int term, input int hold,
                          input bit thr_chg);
    int  rv[3];
    int  d;
    int  dim;
    int  p;
    bit  aborted;
    bit  surv;
    rv[0] = rx; rv[1] = ry; rv[2] = rz;
    d = (qv[0]-rx)*(qv[0]-rx) + (qv[1]-ry)*(qv[1]-ry) + (qv[2]-rz)*(qv[2]-rz);
    check("wait_r_ready", r_ready, 1);
    check("wait_busy", busy, 1);
    r_valid = 1'b1; r_point = pack(rx, ry, rz); r_id = id; r_last = last;
    threshold = 16'(thr);
    @(negedge clk);
    r_valid = 1'b0; r_point = 24'($urandom); r_id = 16'($urandom); r_last = ~last;
    check("clear_bdu_rst", bdu_rst, 1);
    check("clear_code", bdu_code, 0);
    check("clear_r_ready", r_ready, 0);
    aborted = 1'b0;
    for (int s = 0; s < 3*BB; s++) begin
      @(negedge clk);
      dim = s % 3;
      p   = BB - 1 - s / 3;
      check("stream_code", bdu_code, dim + 1);
      check("stream_which", bdu_which_bit, 2*p);
      check("stream_q_bit", bdu_q_bit, (qv[dim] >> p) & 1);
      check("stream_r_bit", bdu_r_bit, (rv[dim] >> p) & 1);
      check("stream_thr", bdu_threshold, thr);
      check("stream_bdu_rst", bdu_rst, 0);
      if (thr_chg && s == 5) threshold = 16'd5;
      if (term == s + 1) begin
        bdu_terminate = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(negedge clk);
      bdu_terminate = 1'b0;
      exp_pruned++;
    end else begin
      @(negedge clk);
      check("drain_code", bdu_code, 0);
      check("drain_res_valid", res_valid, 0);
      surv = (d < thr);
      bdu_done = surv;
      bdu_partial_distance = BB'(d);
      @(negedge clk);
      bdu_done = 1'b0;
      bdu_partial_distance = BB'($urandom);
      if (surv) begin
        check("emit_valid", res_valid, 1);
        check("emit_id", res_id, id);
        check("emit_dist", res_dist, d);
        check("emit_query_done", query_done, 0);
        r_valid = 1'b1;
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("hold_valid", res_valid, 1);
          check("hold_id", res_id, id);
          check("hold_dist", res_dist, d);
          check("hold_r_ready", r_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        r_valid = 1'b0;
        exp_emitted++;
      end else begin
        exp_pruned++;
      end
    end
    check("resolve_code", bdu_code, 0);
    check("resolve_res_valid", res_valid, 0);
    check("resolve_query_done", query_done, last);
    check_stats();
    @(negedge clk);
    check("post_query_done", query_done, 0);
    if (last) begin
      check("post_q_ready", q_ready, 1);
      check("post_busy", busy, 0);
    end else begin
      check("post_r_ready", r_ready, 1);
    end
  endtask

  initial begin
    int ncand;
    int term;
    rst = 1'b1; q_valid = 1'b0; q_point = '0; r_valid = 1'b0; r_point = '0;
    r_id = '0; r_last = 1'b0; threshold = '0; bdu_terminate = 1'b0;
    bdu_done = 1'b0; bdu_partial_distance = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bdu_rst", bdu_rst, 1);
    check("rst_q_ready", q_ready, 1);
    check("rst_r_ready", r_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_code", bdu_code, 0);
    check("rst_which", bdu_which_bit, 0);
    check("rst_thr", bdu_threshold, 0);
    check("rst_res_dist", res_dist, 0);
    check("rst_query_done", query_done, 0);
    check_stats();
    rst = 1'b0;
    @(negedge clk);
    check("idle_bdu_rst", bdu_rst, 0);

    // Emit, abort at stream cycle 20, abort on final stream cycle.
    start_query(3, 4, 0);
    run_cand(0, 0, 0, 16'h0011, 1'b0, 100, 0, 0, 1'b0);
    run_cand(0, 0, 0, 16'h0022, 1'b0, 10, 20, 0, 1'b0);
    run_cand(0, 0, 0, 16'h0033, 1'b1, 100, 24, 0, 1'b0);

    // Threshold change mid-stream, backpressure, then a last survivor.
    start_query(3, 4, 0);
    run_cand(0, 0, 0, 16'h0044, 1'b0, 100, 0, 5, 1'b1);
    run_cand(1, 1, 1, 16'h0055, 1'b1, 100, 0, 0, 1'b0);

    // Reset in stream cycle 10.
    start_query(5, 6, 7);
    check("wait_r_ready_rst", r_ready, 1);
    r_valid = 1'b1; r_point = pack(1, 2, 3); r_id = 16'h0066; r_last = 1'b1;
    threshold = 16'd200;
    @(negedge clk);
    r_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_q_ready", q_ready, 1);
    check("midrst_bdu_rst", bdu_rst, 1);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_query_done", query_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_code", bdu_code, 0);
    check("midrst_thr", bdu_threshold, 0);
    exp_pruned = 0; exp_emitted = 0;
    check_stats();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_query_done", query_done, 0);
    check("postrst_q_ready", q_ready, 1);

    // Randomised queries against the behavioural model.
    for (int q = 0; q < 8; q++) begin
      start_query($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      ncand = $urandom_range(1, 4);
      for (int c = 0; c < ncand; c++) begin
        term = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3*BB) : 0;
        run_cand($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 16'($urandom), (c == ncand - 1), $urandom_range(0, 160), term,
                 $urandom_range(0, 3), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
